exc_ctrl: RTL
=============

Name: exc_ctrl

Overview:
- Exception/interrupt commit controller, directly downstream of the CP0 register file.
- Consumes CP0 status/cause/epc and the timer interrupt, plus the commit-stage exception, interrupt and ERET requests.
- Decides whether to take a trap, sequences the CP0 writes (EPC, then STATUS.EXL) through the single CP0 write port, and flushes, stalls and redirects the pipeline.
- Writes from the in-flight writeback stage are bypassed so that decisions use current CP0 state.

Parameters:
- VEC_NORMAL, 32'h8000_0180, handler address when STATUS.BEV=0
- VEC_BOOT, 32'hBFC0_0380, handler address when STATUS.BEV=1
- PC_W, 32, program-counter width

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- exc_req_i  in  1  commit-stage instruction raised a synchronous exception
- exc_code_i  in  5  ExcCode of that exception
- eret_i  in  1  commit-stage instruction is ERET
- pc_i  in  PC_W  PC of the commit-stage instruction
- in_delay_slot_i  in  1  commit instruction sits in a branch delay slot
- status_i  in  32  CP0 STATUS
- cause_i  in  32  CP0 CAUSE
- epc_i  in  32  CP0 EPC
- timer_int_i  in  1  CP0 timer interrupt
- wb_cp0_we_i  in  1  writeback-stage CP0 write enable
- wb_cp0_waddr_i  in  5  writeback CP0 address
- wb_cp0_data_i  in  32  writeback CP0 data
- cp0_we_o  out  1  CP0 write enable
- cp0_waddr_o  out  5  CP0 write address
- cp0_wdata_o  out  32  CP0 write data
- flush_o  out  1  one-cycle pipeline flush pulse
- stall_o  out  1  hold the pipeline
- redirect_o  out  1  one-cycle fetch redirect pulse
- new_pc_o  out  PC_W  redirect target
- exc_code_o  out  5  latched ExcCode of the taken trap (0 = interrupt)
- exc_bd_o  out  1  latched branch-delay flag of the taken trap

Behaviour:
- Reset (async): state=IDLE; every output and internal latch = 0.
- Bypass: status_eff/cause_eff/epc_eff = wb_cp0_data_i when wb_cp0_we_i=1 and wb_cp0_waddr_i equals 12/13/14 respectively; otherwise status_i/cause_i/epc_i.
  - For CAUSE, only bits 9:8, 22 and 23 take the bypass data; all other bits come from cause_i.
- ip = cause_eff[15:8], with ip[7] ORed with timer_int_i.
- int_pend = status_eff[0] & ~status_eff[1] & |(ip & status_eff[15:8]).
- Decision in IDLE each cycle; priority int_pend > exc_req_i > eret_i.
  - Trap (interrupt or exception): latch epc_t = in_delay_slot_i ? pc_i-4 : pc_i (mod 2^32); latch status_eff.
    - exc_code_o = 0 for interrupt, else exc_code_i.
    - exc_bd_o = in_delay_slot_i.
    - Target = VEC_BOOT if status_eff[22], else VEC_NORMAL.
    - Next state W_EPC.
  - ERET: latch status_eff; target = epc_eff; next state E_STAT.
  - No request: stay in IDLE.
- W_EPC (1 cycle): cp0_we_o=1, waddr=14, wdata=epc_t; flush_o=1; stall_o=1. Next state W_STAT.
- W_STAT (1 cycle): cp0_we_o=1, waddr=12, wdata=latched status with bit1 set; stall_o=1. Next state REDIR.
- E_STAT (1 cycle): cp0_we_o=1, waddr=12, wdata=latched status with bit1 cleared; flush_o=1; stall_o=1. Next state REDIR.
- REDIR (1 cycle): redirect_o=1, new_pc_o=target; cp0_we_o=0; stall_o=0. Next state IDLE.
- All outputs are registered.
  - Latency from request cycle T to redirect: trap T+3, ERET T+2.
  - flush_o asserts exactly at T+1.
- Requests arriving in any state other than IDLE are ignored; the pipeline is flushed or stalled, so no request is lost.
- A request arriving in the same cycle that REDIR returns to IDLE is sampled in the following cycle.
- Outside W_EPC/W_STAT/E_STAT: cp0_we_o=0, waddr=0, wdata=0.
- new_pc_o holds its last value and is meaningful only while redirect_o=1.
- exc_code_o/exc_bd_o hold their values until the next trap.
- Reset asserted mid-sequence aborts immediately: no further writes, no redirect.

Test Plan:
- Exception, IE=1, EXL=0, BEV=0, exc_code_i=8, pc_i=0x80001000, in_delay_slot_i=0 -> T+1 flush_o and write EPC(14)=0x80001000; T+2 write STATUS(12) with bit1=1; T+3 redirect_o with new_pc_o=0x80000180; exc_code_o=8.
- Same exception in a delay slot with BEV=1 -> EPC=0x80000FFC, exc_bd_o=1, new_pc_o=0xBFC00380.
- timer_int_i=1, STATUS=0x0000_8001, simultaneous exc_req_i -> interrupt wins, exc_code_o=0; with STATUS.EXL=1 instead -> no action.
- ERET with epc_i=0x80002000 while WB writes EPC=0x80003000 in the same cycle -> T+1 flush_o and STATUS write with bit1 cleared; T+2 new_pc_o=0x80003000.
- WB writes STATUS=0 (IE cleared) in the cycle an interrupt is pending -> no trap taken.
- Reset asserted during W_STAT -> all outputs 0 immediately, no redirect; a request held during W_EPC is ignored.

Source files
------------

// File: rtl/exc_ctrl.sv
// rtl/exc_ctrl.sv - exception/interrupt commit controller
// Decides traps/ERET at commit, sequences CP0 EPC/STATUS writes, then flushes, stalls and redirects.
module exc_ctrl #(
  parameter logic [31:0] VEC_NORMAL = 32'h8000_0180,
  parameter logic [31:0] VEC_BOOT   = 32'hBFC0_0380,
  parameter int          PC_W       = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            exc_req_i,
  input  logic [4:0]      exc_code_i,
  input  logic            eret_i,
  input  logic [PC_W-1:0] pc_i,
  input  logic            in_delay_slot_i,
  input  logic [31:0]     status_i,
  input  logic [31:0]     cause_i,
  input  logic [31:0]     epc_i,
  input  logic            timer_int_i,
  input  logic            wb_cp0_we_i,
  input  logic [4:0]      wb_cp0_waddr_i,
  input  logic [31:0]     wb_cp0_data_i,
  output logic            cp0_we_o,
  output logic [4:0]      cp0_waddr_o,
  output logic [31:0]     cp0_wdata_o,
  output logic            flush_o,
  output logic            stall_o,
  output logic            redirect_o,
  output logic [PC_W-1:0] new_pc_o,
  output logic [4:0]      exc_code_o,
  output logic            exc_bd_o
);
  typedef enum logic [2:0] {IDLE, W_EPC, W_STAT, E_STAT, REDIR} state_t;

  localparam logic [4:0] A_STATUS = 5'd12;
  localparam logic [4:0] A_CAUSE  = 5'd13;
  localparam logic [4:0] A_EPC    = 5'd14;

  state_t            state, state_n;
  logic [31:0]       status_lat, status_lat_n;
  logic [PC_W-1:0]   target, target_n;
  logic              we_n, flush_n, stall_n, redir_n, bd_n;
  logic [4:0]        waddr_n, code_n;
  logic [31:0]       wdata_n;
  logic [PC_W-1:0]   new_pc_n;

  logic [31:0] status_eff, cause_eff, epc_eff, epc_t;
  logic [7:0]  ip;
  logic        int_pend;
  logic        unused_cause;

  // Bypass the in-flight WB write so decisions see the CP0 state it is about to create.
  always_comb begin
    status_eff = (wb_cp0_we_i && wb_cp0_waddr_i == A_STATUS) ? wb_cp0_data_i : status_i;
    epc_eff    = (wb_cp0_we_i && wb_cp0_waddr_i == A_EPC)    ? wb_cp0_data_i : epc_i;
    cause_eff  = cause_i;
    if (wb_cp0_we_i && wb_cp0_waddr_i == A_CAUSE) begin
      cause_eff[9:8]   = wb_cp0_data_i[9:8];
      cause_eff[23:22] = wb_cp0_data_i[23:22];
    end
    ip       = cause_eff[15:8];
    ip[7]    = ip[7] | timer_int_i;
    int_pend = status_eff[0] & ~status_eff[1] & (|(ip & status_eff[15:8]));
    epc_t    = 32'(in_delay_slot_i ? (pc_i - PC_W'(4)) : pc_i);
  end

  assign unused_cause = ^{cause_eff[31:16], cause_eff[7:0]};

  always_comb begin
    state_n      = state;
    status_lat_n = status_lat;
    target_n     = target;
    we_n         = 1'b0;
    waddr_n      = 5'd0;
    wdata_n      = 32'd0;
    flush_n      = 1'b0;
    stall_n      = 1'b0;
    redir_n      = 1'b0;
    new_pc_n     = new_pc_o;
    code_n       = exc_code_o;
    bd_n         = exc_bd_o;
    case (state)
      IDLE: begin
        if (int_pend || exc_req_i) begin
          state_n      = W_EPC;
          status_lat_n = status_eff;
          target_n     = status_eff[22] ? PC_W'(VEC_BOOT) : PC_W'(VEC_NORMAL);
          code_n       = int_pend ? 5'd0 : exc_code_i;
          bd_n         = in_delay_slot_i;
          we_n         = 1'b1;
          waddr_n      = A_EPC;
          wdata_n      = epc_t;
          flush_n      = 1'b1;
          stall_n      = 1'b1;
        end else if (eret_i) begin
          state_n      = E_STAT;
          status_lat_n = status_eff;
          target_n     = PC_W'(epc_eff);
          we_n         = 1'b1;
          waddr_n      = A_STATUS;
          wdata_n      = status_eff & ~32'h2;
          flush_n      = 1'b1;
          stall_n      = 1'b1;
        end
      end
      W_EPC: begin
        state_n = W_STAT;
        we_n    = 1'b1;
        waddr_n = A_STATUS;
        wdata_n = status_lat | 32'h2;
        stall_n = 1'b1;
      end
      W_STAT, E_STAT: begin
        state_n  = REDIR;
        redir_n  = 1'b1;
        new_pc_n = target;
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next-state decode, so they line up with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      status_lat  <= '0;
      target      <= '0;
      cp0_we_o    <= 1'b0;
      cp0_waddr_o <= '0;
      cp0_wdata_o <= '0;
      flush_o     <= 1'b0;
      stall_o     <= 1'b0;
      redirect_o  <= 1'b0;
      new_pc_o    <= '0;
      exc_code_o  <= '0;
      exc_bd_o    <= 1'b0;
    end else begin
      state       <= state_n;
      status_lat  <= status_lat_n;
      target      <= target_n;
      cp0_we_o    <= we_n;
      cp0_waddr_o <= waddr_n;
      cp0_wdata_o <= wdata_n;
      flush_o     <= flush_n;
      stall_o     <= stall_n;
      redirect_o  <= redir_n;
      new_pc_o    <= new_pc_n;
      exc_code_o  <= code_n;
      exc_bd_o    <= bd_n;
    end
  end
endmodule
